sccb_config_ctrl: RTL and testbench

SCCB_CONFIG_CTRL -- requirements
Module: sccb_config_ctrl

---
 rtl/cam_pkg.sv | 20 ++
 rtl/cam_reg_rom.sv | 29 ++
 rtl/sccb_config_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_sccb_config_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared constants and FSM state type for the camera SCCB configurator
package cam_pkg;

    localparam logic [7:0]  CAM_DEV_ID   = 8'h42;
    localparam logic [15:0] CAM_END_MARK = 16'hFFFF;
    localparam logic [7:0]  CAM_RST_ADDR = 8'h12;
    localparam logic [7:0]  CAM_LAST_IDX = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_BYTE,
        ST_STOP,
        ST_GAP,
        ST_WAIT_RST,
        ST_FINISH
    } cam_state_t;

endpackage

// File: rtl/cam_reg_rom.sv
// rtl/cam_reg_rom.sv - camera register table ROM, CAM_TEST_PATTERN_EN appends colour-bar entries
module cam_reg_rom
    import cam_pkg::*;
(
    input  logic [7:0]  idx,
    output logic [15:0] entry
);

    // Table lookup: {addr,data} per index, end marker everywhere past the table
    always_comb begin
        entry = CAM_END_MARK;
        case (idx)
            8'd0:    entry = 16'h1280;
            8'd1:    entry = 16'h1214;
            8'd2:    entry = 16'h40D0;
            8'd3:    entry = 16'h8C00;
            8'd4:    entry = 16'h0C00;
            8'd5:    entry = 16'h3E00;
            8'd6:    entry = 16'h703A;
            8'd7:    entry = 16'h7135;
`ifdef CAM_TEST_PATTERN_EN
            8'd8:    entry = 16'h70BA;
            8'd9:    entry = 16'h71B5;
`endif
            default: entry = CAM_END_MARK;
        endcase
    end

endmodule

// File: rtl/sccb_config_ctrl.sv
// rtl/sccb_config_ctrl.sv - SCCB write sequencer for camera register table (CAM_TEST_PATTERN_EN in ROM)
module sccb_config_ctrl
    import cam_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 125,
    parameter int unsigned RST_WAIT_Q = 400000,
    parameter logic [7:0]  DEV_ID     = CAM_DEV_ID
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       sioc,
    output logic       siod_out,
    output logic       siod_oe,
    output logic       busy,
    output logic       done,
    output logic [7:0] reg_idx
);

    localparam logic [31:0] DIV_LAST  = 32'(CLK_DIV - 1);
    localparam logic [31:0] WAIT_LAST = 32'(RST_WAIT_Q - 1);

    cam_state_t  state;
    cam_state_t  state_next;
    logic [31:0] div_cnt;
    logic [31:0] q_cnt;
    logic [31:0] q_last;
    logic [1:0]  phase;
    logic [3:0]  bitpos;
    logic [15:0] rom_entry;
    logic [15:0] entry_r;
    logic [7:0]  cur_byte;
    logic        done_r;
    logic        tick;
    logic        end_q;
    logic        adv_idx;

    cam_reg_rom u_rom (
        .idx   (reg_idx),
        .entry (rom_entry)
    );

    assign busy  = (state != ST_IDLE) && (state != ST_FINISH);
    assign done  = done_r;
    assign tick  = busy && (div_cnt == DIV_LAST);
    assign end_q = tick && (q_cnt == q_last);

    // Quarter count of the last quarter in the current state (per bit in BYTE)
    always_comb begin
        q_last = '0;
        case (state)
            ST_START:    q_last = 32'd2;
            ST_BYTE:     q_last = 32'd3;
            ST_STOP:     q_last = 32'd2;
            ST_GAP:      q_last = 32'd3;
            ST_WAIT_RST: q_last = WAIT_LAST;
            default:     q_last = '0;
        endcase
    end

    // Byte being shifted: device address, then register address, then data
    always_comb begin
        cur_byte = DEV_ID;
        case (phase)
            2'd0:    cur_byte = DEV_ID;
            2'd1:    cur_byte = entry_r[15:8];
            default: cur_byte = entry_r[7:0];
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and bus drive; idle bus is SIOC high with SIOD released
    always_comb begin
        state_next = state;
        adv_idx    = 1'b0;
        sioc       = 1'b1;
        siod_out   = 1'b1;
        siod_oe    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                if (rom_entry == CAM_END_MARK || reg_idx == CAM_LAST_IDX) state_next = ST_FINISH;
                else                                                        state_next = ST_START;
            end
            ST_START: begin
                siod_oe  = 1'b1;
                siod_out = (q_cnt == 32'd0);
                sioc     = (q_cnt != 32'd2);
                if (end_q) state_next = ST_BYTE;
            end
            ST_BYTE: begin
                sioc = (q_cnt == 32'd1) || (q_cnt == 32'd2);
                if (bitpos != 4'd8) begin
                    siod_oe  = 1'b1;
                    siod_out = cur_byte[3'd7 - bitpos[2:0]];
                end
                if (end_q && bitpos == 4'd8 && phase == 2'd2) state_next = ST_STOP;
            end
            ST_STOP: begin
                siod_oe  = 1'b1;
                sioc     = (q_cnt != 32'd0);
                siod_out = (q_cnt == 32'd2);
                if (end_q) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (end_q) begin
                    if (entry_r[15:8] == CAM_RST_ADDR && entry_r[7]) begin
                        state_next = ST_WAIT_RST;
                    end else begin
                        state_next = ST_LOAD;
                        adv_idx    = 1'b1;
                    end
                end
            end
            ST_WAIT_RST: begin
                if (end_q) begin
                    state_next = ST_LOAD;
                    adv_idx    = 1'b1;
                end
            end
            ST_FINISH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Quarter divider, per-state quarter/bit counters, table index and done flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            q_cnt   <= '0;
            bitpos  <= '0;
            phase   <= '0;
            reg_idx <= '0;
            entry_r <= '0;
            done_r  <= 1'b0;
        end else begin
            if (state_next == ST_START && state != ST_START) div_cnt <= '0;
            else if (tick || !busy)                          div_cnt <= '0;
            else                                             div_cnt <= div_cnt + 32'd1;

            if (state_next != state) begin
                q_cnt  <= '0;
                bitpos <= '0;
                phase  <= '0;
            end else if (tick) begin
                if (state == ST_BYTE && q_cnt == 32'd3) begin
                    q_cnt <= '0;
                    if (bitpos == 4'd8) begin
                        bitpos <= '0;
                        phase  <= phase + 2'd1;
                    end else begin
                        bitpos <= bitpos + 4'd1;
                    end
                end else begin
                    q_cnt <= q_cnt + 32'd1;
                end
            end

            if (state == ST_IDLE && start) reg_idx <= '0;
            else if (adv_idx)              reg_idx <= reg_idx + 8'd1;

            if (state == ST_LOAD) entry_r <= rom_entry;

            if (state == ST_IDLE && start)   done_r <= 1'b0;
            else if (state_next == ST_FINISH) done_r <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sccb_config_ctrl.sv
// tb/tb_sccb_config_ctrl.sv - randomized bench for sccb_config_ctrl with SCCB frame decoder (honours CAM_TEST_PATTERN_EN)
module tb_sccb_config_ctrl;

    localparam int         CLK_DIV    = 2;
    localparam int         RST_WAIT_Q = 8;
    localparam logic [7:0] DEV        = 8'h42;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       start = 1'b0;
    logic       sioc;
    logic       siod_out;
    logic       siod_oe;
    logic       busy;
    logic       done;
    logic [7:0] reg_idx;

    sccb_config_ctrl #(
        .CLK_DIV    (CLK_DIV),
        .RST_WAIT_Q (RST_WAIT_Q),
        .DEV_ID     (DEV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .sioc     (sioc),
        .siod_out (siod_out),
        .siod_oe  (siod_oe),
        .busy     (busy),
        .done     (done),
        .reg_idx  (reg_idx)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        int         nbits;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        bit         ack_rel;
        bit         data_drv;
        int         gap_q;
    } frame_t;

    frame_t      frames[$];
    int          bits_q[$];
    logic [15:0] exp_tab[$];
    bit          in_frame;
    logic        p_sioc;
    logic        p_siod;
    logic        p_oe;
    int          idle_run;
    int          last_idle;
    int          cur_gap;
    frame_t      fr;
    logic        bv;

    // Bus decoder: start/stop conditions, one bit per SIOC rise, idle length before each start
    initial forever begin
        @(negedge clk);
        if (rst) begin
            in_frame  = 1'b0;
            bits_q.delete();
            idle_run  = 0;
            last_idle = 0;
            p_sioc    = 1'b1;
            p_siod    = 1'b1;
            p_oe      = 1'b0;
        end else begin
            if (siod_oe && !p_oe && sioc) last_idle = idle_run;
            if (sioc && p_sioc && siod_oe && p_siod && !siod_out) begin
                in_frame = 1'b1;
                bits_q.delete();
                cur_gap  = last_idle;
            end else if (in_frame && sioc && !p_sioc) begin
                bits_q.push_back(siod_oe ? int'(siod_out) : 2);
            end else if (in_frame && sioc && p_sioc && siod_oe && p_oe && !p_siod && siod_out) begin
                fr.nbits    = bits_q.size() - 1;
                fr.b0       = '0;
                fr.b1       = '0;
                fr.b2       = '0;
                fr.ack_rel  = 1'b1;
                fr.data_drv = 1'b1;
                fr.gap_q    = cur_gap / CLK_DIV;
                for (int i = 0; i < 27 && i < fr.nbits; i++) begin
                    if (i % 9 == 8) begin
                        if (bits_q[i] != 2) fr.ack_rel = 1'b0;
                    end else begin
                        if (bits_q[i] == 2) fr.data_drv = 1'b0;
                        bv = (bits_q[i] == 1);
                        if (i < 9)       fr.b0 = {fr.b0[6:0], bv};
                        else if (i < 18) fr.b1 = {fr.b1[6:0], bv};
                        else             fr.b2 = {fr.b2[6:0], bv};
                    end
                end
                frames.push_back(fr);
                in_frame = 1'b0;
            end
            idle_run = (!siod_oe && sioc) ? idle_run + 1 : 0;
            p_sioc   = sioc;
            p_siod   = siod_out;
            p_oe     = siod_oe;
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_seq(input bit inject, input string tag);
        int          base;
        int          n;
        int          cyc;
        int          got_n;
        logic [15:0] e;
        logic [15:0] pe;
        base = frames.size();
        n    = exp_tab.size();
        repeat ($urandom_range(1, 20)) @(negedge clk);
        pulse_start();
        check_eq({tag, ".busy_after_start"}, busy, 1);
        check_eq({tag, ".done_cleared"}, done, 0);
        if (inject) begin
            repeat ($urandom_range(50, 1400)) @(negedge clk);
            #1;
            cyc = 0;
            while (!(in_frame && !sioc && siod_oe) && cyc < 3000) begin
                @(negedge clk);
                #1;
                cyc++;
            end
            if (busy) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                #1;
                check_eq({tag, ".restart_ignored_idx"}, reg_idx, frames.size() - base);
                check_eq({tag, ".restart_busy"}, busy, 1);
            end
        end
        cyc = 0;
        while (done !== 1'b1 && cyc < 10000) begin
            @(negedge clk);
            cyc++;
        end
        check_eq({tag, ".done"}, done, 1);
        check_eq({tag, ".busy_at_finish"}, busy, 0);
        check_eq({tag, ".idx_at_finish"}, reg_idx, n);
        got_n = frames.size() - base;
        check_eq({tag, ".nwrites"}, got_n, n);
        for (int k = 0; k < n && k < got_n; k++) begin
            e = exp_tab[k];
            check_eq($sformatf("%s.w%0d.nbits", tag, k), frames[base + k].nbits, 27);
            check_eq($sformatf("%s.w%0d.dev", tag, k), frames[base + k].b0, DEV);
            check_eq($sformatf("%s.w%0d.addr", tag, k), frames[base + k].b1, e[15:8]);
            check_eq($sformatf("%s.w%0d.data", tag, k), frames[base + k].b2, e[7:0]);
            check_eq($sformatf("%s.w%0d.ack_released", tag, k), frames[base + k].ack_rel, 1);
            check_eq($sformatf("%s.w%0d.data_driven", tag, k), frames[base + k].data_drv, 1);
            if (k > 0) begin
                pe = exp_tab[k - 1];
                check_eq($sformatf("%s.w%0d.gap_quarters", tag, k), frames[base + k].gap_q,
                         4 + ((pe[15:8] == 8'h12 && pe[7]) ? RST_WAIT_Q : 0));
            end
        end
        repeat ($urandom_range(2, 30)) @(negedge clk);
        check_eq({tag, ".done_sticky"}, done, 1);
        check_eq({tag, ".busy_idle"}, busy, 0);
    endtask

    task automatic reset_mid(input int k);
        int base;
        int cyc;
        base = frames.size();
        pulse_start();
        #1;
        cyc = 0;
        while (!(in_frame && (frames.size() - base) == k && bits_q.size() == 15) && cyc < 20000) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_eq("rst_mid.reached_addr_bit5", bits_q.size(), 15);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid.sioc", sioc, 1);
        check_eq("rst_mid.siod_oe", siod_oe, 0);
        check_eq("rst_mid.siod_out", siod_out, 1);
        check_eq("rst_mid.busy", busy, 0);
        check_eq("rst_mid.done", done, 0);
        check_eq("rst_mid.reg_idx", reg_idx, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        exp_tab = '{16'h1280, 16'h1214, 16'h40D0, 16'h8C00, 16'h0C00, 16'h3E00, 16'h703A, 16'h7135};
`ifdef CAM_TEST_PATTERN_EN
        exp_tab.push_back(16'h70BA);
        exp_tab.push_back(16'h71B5);
`endif
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset.sioc", sioc, 1);
        check_eq("reset.siod_out", siod_out, 1);
        check_eq("reset.siod_oe", siod_oe, 0);
        check_eq("reset.busy", busy, 0);
        check_eq("reset.done", done, 0);
        check_eq("reset.reg_idx", reg_idx, 0);
        @(negedge clk);
        rst = 1'b0;

        run_seq(1'b1, "run1");
        run_seq(1'b0, "run2");
        reset_mid($urandom_range(0, exp_tab.size() - 1));
        run_seq(1'b1, "run3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
